multicycle_ctrl: RTL

Multi-cycle control sequencer for the 32-bit MIPS datapath. It replaces the single-cycle decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and write-back phases. This lets one ALU and one unified memory port be shared across cycles. It sits beside the datapath, taking `op`/`funct` from the registered instruction register and `alu_zero` from the ALU, and driving every mux select and write enable.

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic             sign_ext;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, funct, alu_zero, mem_ready,
    output pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_ext, pc_source,
           state, instr_done, illegal, instr_count
  );

  modport slave (
    output op, funct, alu_zero, mem_ready,
    input  pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_ext, pc_source,
           state, instr_done, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath select.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] F_SLL  = 6'h00;
  localparam logic [OP_W-1:0] F_SRL  = 6'h02;
  localparam logic [OP_W-1:0] F_ADD  = 6'h20;
  localparam logic [OP_W-1:0] F_ADDU = 6'h21;
  localparam logic [OP_W-1:0] F_SUB  = 6'h22;
  localparam logic [OP_W-1:0] F_SUBU = 6'h23;
  localparam logic [OP_W-1:0] F_AND  = 6'h24;
  localparam logic [OP_W-1:0] F_OR   = 6'h25;
  localparam logic [OP_W-1:0] F_XOR  = 6'h26;
  localparam logic [OP_W-1:0] F_NOR  = 6'h27;
  localparam logic [OP_W-1:0] F_SLT  = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 4'h0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'h1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'h2;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'h3;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'h6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'h7;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'h8;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'h9;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'hC;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  typedef struct packed {
    logic             pc_en;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_op;
    logic             sign_ext;
    logic [1:0]       pc_source;
    logic             instr_done;
    logic             illegal;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  ctrl_t            ctrl_c, ctrl_out_c;
  logic [ALU_W-1:0] r_alu_op_c, i_alu_op_c;
  logic             r_legal_c, r_shift_c;

  // R-type funct decode; IR is stable for the whole instruction
  always_comb begin
    r_alu_op_c = ALU_ADD;
    r_legal_c  = 1'b1;
    r_shift_c  = 1'b0;
    case (bus.funct)
      F_ADD, F_ADDU: r_alu_op_c = ALU_ADD;
      F_SUB, F_SUBU: r_alu_op_c = ALU_SUB;
      F_AND:         r_alu_op_c = ALU_AND;
      F_OR:          r_alu_op_c = ALU_OR;
      F_XOR:         r_alu_op_c = ALU_XOR;
      F_NOR:         r_alu_op_c = ALU_NOR;
      F_SLT:         r_alu_op_c = ALU_SLT;
      F_SLL: begin
        r_alu_op_c = ALU_SLL;
        r_shift_c  = 1'b1;
      end
      F_SRL: begin
        r_alu_op_c = ALU_SRL;
        r_shift_c  = 1'b1;
      end
      default:       r_legal_c  = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_ANDI: i_alu_op_c = ALU_AND;
      OP_ORI:  i_alu_op_c = ALU_OR;
      default: i_alu_op_c = ALU_ADD;
    endcase
  end

  // Next state and per-state control levels
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = 2'd1;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_en     = bus.mem_ready;
        ctrl_c.ir_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = 2'd3;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.sign_ext  = 1'b1;
        case (bus.op)
          OP_RTYPE: begin
            if (r_legal_c) begin
              state_d = S_R_EXE;
            end else begin
              ctrl_c.illegal = 1'b1;
              state_d        = S_FETCH;
            end
          end
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_I_EXE;
          default: begin
            ctrl_c.illegal = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 2'd1;
        ctrl_c.alu_src_b = 2'd2;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_c.iord      = 1'b1;
        ctrl_c.mem_write = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_R_EXE: begin
        ctrl_c.alu_src_a = r_shift_c ? 2'd2 : 2'd1;
        ctrl_c.alu_op    = r_alu_op_c;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a  = 2'd1;
        ctrl_c.alu_op     = ALU_SUB;
        ctrl_c.pc_source  = 2'd1;
        ctrl_c.pc_en      = bus.alu_zero ^ (bus.op == OP_BNE);
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_source  = 2'd2;
        ctrl_c.pc_en      = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_I_EXE: begin
        ctrl_c.alu_src_a = 2'd1;
        ctrl_c.alu_src_b = 2'd2;
        ctrl_c.alu_op    = i_alu_op_c;
        ctrl_c.sign_ext  = (bus.op == OP_ADDI);
        state_d          = S_I_WB;
      end
      S_I_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q + CNT_W'(ctrl_c.instr_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Hold every strobe low while reset is asserted, including FETCH's mem_read
  assign ctrl_out_c = rst ? ctrl_c : '0;

  assign bus.pc_en       = ctrl_out_c.pc_en;
  assign bus.ir_write    = ctrl_out_c.ir_write;
  assign bus.iord        = ctrl_out_c.iord;
  assign bus.mem_read    = ctrl_out_c.mem_read;
  assign bus.mem_write   = ctrl_out_c.mem_write;
  assign bus.reg_write   = ctrl_out_c.reg_write;
  assign bus.reg_dst     = ctrl_out_c.reg_dst;
  assign bus.mem_to_reg  = ctrl_out_c.mem_to_reg;
  assign bus.alu_src_a   = ctrl_out_c.alu_src_a;
  assign bus.alu_src_b   = ctrl_out_c.alu_src_b;
  assign bus.alu_op      = ctrl_out_c.alu_op;
  assign bus.sign_ext    = ctrl_out_c.sign_ext;
  assign bus.pc_source   = ctrl_out_c.pc_source;
  assign bus.instr_done  = ctrl_out_c.instr_done;
  assign bus.illegal     = ctrl_out_c.illegal;
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;
endmodule
